// File: rtl/sdram_sched_pkg.sv
// Shared encodings for the SDRAM burst scheduler.
// FSM state codes, grant codes and the default address width.
package sdram_sched_pkg;

  localparam int ADDR_W_DEF = 24;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_BUSY = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_BUSY = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    WR_REQ  = S_WR_REQ,
    WR_BUSY = S_WR_BUSY,
    RD_REQ  = S_RD_REQ,
    RD_BUSY = S_RD_BUSY,
    GAP     = S_GAP
  } state_e;

  localparam logic G_WR = 1'b0;
  localparam logic G_RD = 1'b1;

endpackage

// File: rtl/sdram_ring_ptr.sv
// Circular-buffer pointer: advances by burst_len, wraps at DEPTH,
// and presents a registered BASE_ADDR-offset word address.
import sdram_sched_pkg::*;

module sdram_ring_ptr #(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] DEPTH     = ADDR_W'(4096)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  input  logic [9:0]        burst_len_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   sum;
  logic [ADDR_W:0]   depth_x;

  assign depth_x = {1'b0, DEPTH};

  always_comb begin
    sum    = {1'b0, ptr_q} + {{(ADDR_W-9){1'b0}}, burst_len_i};
    ptr_d  = ptr_q;
    if (adv_i) begin
      if (sum >= depth_x) begin
        ptr_d = ADDR_W'(sum - depth_x);
      end else begin
        ptr_d = sum[ADDR_W-1:0];
      end
    end
    addr_d = BASE_ADDR + ptr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      addr_q <= BASE_ADDR;
    end else begin
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/sdram_burst_sched.sv
// SDRAM burst scheduler sharing one controller port between the UART
// write and read paths. Define SDRAM_SCHED_RR_EN for round-robin ties.
import sdram_sched_pkg::*;

module sdram_burst_sched #(
  parameter int                ADDR_W        = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter logic [ADDR_W-1:0] DEPTH         = ADDR_W'(4096),
  parameter logic [10:0]       RD_FIFO_DEPTH = 11'd1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic [9:0]        burst_len,
  input  logic [9:0]        wr_fifo_cnt,
  input  logic [9:0]        rd_fifo_cnt,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  input  logic              wr_end,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_end,
  output logic [ADDR_W:0]   occupancy,
  output logic              busy
);

  state_e          state_q, state_d;
  logic            wr_req_q, wr_req_d;
  logic            rd_req_q, rd_req_d;
  logic [ADDR_W:0] occ_q, occ_d;
  logic            wr_adv, rd_adv;

  logic [ADDR_W:0] bl_x;
  logic [ADDR_W:0] occ_sum;
  logic [10:0]     rd_sum;
  logic            bl_ok;
  logic            wr_elig, rd_elig;
  logic            pick_wr;

  assign bl_x    = {{(ADDR_W-9){1'b0}}, burst_len};
  assign occ_sum = occ_q + bl_x;
  assign rd_sum  = {1'b0, rd_fifo_cnt} + {1'b0, burst_len};
  assign bl_ok   = |burst_len;

  assign wr_elig = init_done & bl_ok
                 & (wr_fifo_cnt >= burst_len)
                 & (occ_sum <= {1'b0, DEPTH});
  assign rd_elig = init_done & bl_ok
                 & (occ_q >= bl_x)
                 & (rd_sum <= RD_FIFO_DEPTH);

`ifdef SDRAM_SCHED_RR_EN
  logic last_q, last_d;

  // On a tie, serve the direction that did not complete last.
  assign pick_wr = wr_elig & (~rd_elig | (last_q == G_RD));

  always_comb begin
    last_d = last_q;
    if (wr_adv) last_d = G_WR;
    if (rd_adv) last_d = G_RD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= G_RD;
    else        last_q <= last_d;
  end
`else
  assign pick_wr = wr_elig;
`endif

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    wr_adv  = 1'b0;
    rd_adv  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_wr)      state_d = WR_REQ;
        else if (rd_elig) state_d = RD_REQ;
      end
      WR_REQ: begin
        if (wr_ack) state_d = WR_BUSY;
      end
      WR_BUSY: begin
        if (wr_end) begin
          wr_adv  = 1'b1;
          occ_d   = occ_sum;
          state_d = GAP;
        end
      end
      RD_REQ: begin
        if (rd_ack) state_d = RD_BUSY;
      end
      RD_BUSY: begin
        if (rd_end) begin
          rd_adv  = 1'b1;
          occ_d   = occ_q - bl_x;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    wr_req_d = (state_d == WR_REQ);
    rd_req_d = (state_d == RD_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      occ_q    <= occ_d;
    end
  end

  sdram_ring_ptr #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .DEPTH    (DEPTH)
  ) u_wr_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (wr_adv),
    .burst_len_i(burst_len),
    .addr_o     (wr_addr)
  );

  sdram_ring_ptr #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .DEPTH    (DEPTH)
  ) u_rd_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (rd_adv),
    .burst_len_i(burst_len),
    .addr_o     (rd_addr)
  );

  assign wr_req    = wr_req_q;
  assign rd_req    = rd_req_q;
  assign occupancy = occ_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Randomized bench for sdram_burst_sched against a circular-buffer model.
// Honours SDRAM_SCHED_RR_EN when predicting tie grants.
module tb_sdram_burst_sched;

  localparam int          AW   = 24;
  localparam logic [23:0] BASE = 24'h000100;
  localparam int          DEP  = 40;
  localparam int          RFD  = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done = 1'b0;
  logic [9:0]    burst_len = '0;
  logic [9:0]    wr_fifo_cnt = '0;
  logic [9:0]    rd_fifo_cnt = '0;
  logic          wr_ack = 1'b0;
  logic          wr_end = 1'b0;
  logic          rd_ack = 1'b0;
  logic          rd_end = 1'b0;
  logic          wr_req, rd_req, busy;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   occupancy;

  sdram_burst_sched #(
    .ADDR_W       (AW),
    .BASE_ADDR    (BASE),
    .DEPTH        (24'(DEP)),
    .RD_FIFO_DEPTH(11'(RFD))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .burst_len  (burst_len),
    .wr_fifo_cnt(wr_fifo_cnt),
    .rd_fifo_cnt(rd_fifo_cnt),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_ack     (wr_ack),
    .wr_end     (wr_end),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_end     (rd_end),
    .occupancy  (occupancy),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: stored words, pointers, last completed grant
  int m_occ = 0;
  int m_wp  = 0;
  int m_rp  = 0;
  bit m_last_rd = 1'b1;
  int bl = 10;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_pulses();
    wr_ack = 1'b0;
    wr_end = 1'b0;
    rd_ack = 1'b0;
    rd_end = 1'b0;
  endtask

  task automatic model_reset();
    m_occ     = 0;
    m_wp      = 0;
    m_rp      = 0;
    m_last_rd = 1'b1;
  endtask

  // Called at a negedge with the DUT in IDLE; returns the same way.
  task automatic burst(input bit ini, input int wf, input int rf);
    bit we, re, gw;
    int n, ea;
    init_done   = ini;
    wr_fifo_cnt = 10'(wf);
    rd_fifo_cnt = 10'(rf);
    burst_len   = 10'(bl);
    we = ini && bl != 0 && wf >= bl && m_occ + bl <= DEP;
    re = ini && bl != 0 && m_occ >= bl && rf + bl <= RFD;
    @(negedge clk);
    if (!we && !re) begin
      chk("noelig_wr_req", 32'(wr_req), 0);
      chk("noelig_rd_req", 32'(rd_req), 0);
      chk("noelig_busy", 32'(busy), 0);
      return;
    end
`ifdef SDRAM_SCHED_RR_EN
    gw = we && (!re || m_last_rd);
`else
    gw = we;
`endif
    ea = int'(BASE) + (gw ? m_wp : m_rp);
    chk("grant_wr", 32'(wr_req), 32'(gw));
    chk("grant_rd", 32'(rd_req), 32'(!gw));
    chk("req_addr", gw ? 32'(wr_addr) : 32'(rd_addr), ea);
    n = $urandom_range(0, 3);
    repeat (n) begin
      if (gw) begin
        wr_end = 1'b1;
        rd_ack = 1'($urandom);
        rd_end = 1'($urandom);
      end else begin
        rd_end = 1'b1;
        wr_ack = 1'($urandom);
        wr_end = 1'($urandom);
      end
      @(negedge clk);
      clr_pulses();
      chk("req_hold", gw ? 32'(wr_req) : 32'(rd_req), 1);
      chk("req_occ_hold", 32'(occupancy), m_occ);
    end
    if (gw) wr_ack = 1'b1;
    else    rd_ack = 1'b1;
    init_done = 1'($urandom_range(0, 1));
    @(negedge clk);
    clr_pulses();
    chk("req_drop", 32'(wr_req | rd_req), 0);
    chk("busy_burst", 32'(busy), 1);
    n = $urandom_range(0, 3);
    repeat (n) begin
      if (gw) begin
        wr_ack = 1'b1;
        rd_ack = 1'($urandom);
        rd_end = 1'($urandom);
      end else begin
        rd_ack = 1'b1;
        wr_ack = 1'($urandom);
        wr_end = 1'($urandom);
      end
      @(negedge clk);
      clr_pulses();
      chk("busy_occ_hold", 32'(occupancy), m_occ);
      chk("busy_addr", gw ? 32'(wr_addr) : 32'(rd_addr), ea);
      chk("busy_noreq", 32'(wr_req | rd_req), 0);
    end
    if (gw) wr_end = 1'b1;
    else    rd_end = 1'b1;
    @(negedge clk);
    clr_pulses();
    if (gw) begin
      m_occ     = m_occ + bl;
      m_wp      = (m_wp + bl) % DEP;
      m_last_rd = 1'b0;
    end else begin
      m_occ     = m_occ - bl;
      m_rp      = (m_rp + bl) % DEP;
      m_last_rd = 1'b1;
    end
    chk("end_occ", 32'(occupancy), m_occ);
    chk("gap_busy", 32'(busy), 1);
    chk("end_addr", gw ? 32'(wr_addr) : 32'(rd_addr),
        int'(BASE) + (gw ? m_wp : m_rp));
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_noreq", 32'(wr_req | rd_req), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && m_occ > 0; i++) burst(1'b1, 0, 0);
  endtask

  int bl_tab[8] = '{1, 2, 4, 5, 8, 10, 20, 40};

  initial begin
    int wf, rf;
    bit ini;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_wr_addr", 32'(wr_addr), 32'(BASE));
    chk("rst_rd_addr", 32'(rd_addr), 32'(BASE));
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // write only, then read gating on read-FIFO room
    bl = 10;
    burst(1'b1, 10, 0);
    burst(1'b1, 0, 1020);
    burst(1'b1, 0, 1014);
    chk("after_read_occ", 32'(occupancy), 0);

    // fill to DEPTH, wrap, withheld fifth write
    repeat (4) burst(1'b1, 10, 1020);
    chk("full_occ", 32'(occupancy), 40);
    burst(1'b1, 10, 1020);
    burst(1'b1, 0, 0);
    burst(1'b1, 10, 1020);
    drain();

    // both directions eligible continuously
    repeat (6) burst(1'b1, 10, 0);
    drain();

    // init_done low blocks new bursts
    burst(1'b0, 10, 0);

    for (int it = 0; it < 200; it++) begin
      if (m_occ == 0 && $urandom_range(0, 3) == 0)
        bl = bl_tab[$urandom_range(0, 7)];
      ini = ($urandom_range(0, 9) != 0);
      wf  = $urandom_range(0, 1) ? bl + $urandom_range(0, 20)
                                 : $urandom_range(0, bl);
      rf  = $urandom_range(0, 1) ? $urandom_range(RFD - bl - 3, RFD - 1)
                                 : $urandom_range(0, 1000);
      burst(ini, wf, rf);
    end
    drain();

    // reset in WR_BUSY with 20 words stored
    bl = 10;
    burst(1'b1, 10, 1020);
    burst(1'b1, 10, 1020);
    chk("pre_rst_occ", 32'(occupancy), 20);
    init_done   = 1'b1;
    wr_fifo_cnt = 10'd10;
    @(negedge clk);
    chk("pre_rst_req", 32'(wr_req), 1);
    wr_ack = 1'b1;
    @(negedge clk);
    clr_pulses();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_occ", 32'(occupancy), 0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'(BASE));
    chk("midrst_rd_addr", 32'(rd_addr), 32'(BASE));
    chk("midrst_req", 32'(wr_req | rd_req), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    burst(1'b1, 10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_burst_sched.md
# sdram_burst_sched

Burst scheduler that shares the single SDRAM controller port between the UART write path (write FIFO → SDRAM) and the UART read path (SDRAM → read FIFO → uart_rd_fifo). It treats a region of SDRAM as a circular buffer and tracks its write pointer, read pointer and occupancy. It grants one burst at a time and issues request/address handshakes to the SDRAM controller. Bursts are released only when the source FIFO holds a full burst and the destination can take it.

## Interface
- ADDR_W, 24, SDRAM word-address width
- BASE_ADDR, 24'd0, first word of the circular region
- DEPTH, 24'd4096, region size in words; must be an integer multiple of every burst_len used
- RD_FIFO_DEPTH, 11'd1024, capacity of the SDRAM read FIFO in words

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- init_done  in  1  SDRAM initialisation complete; no request is issued while low
- burst_len  in  10  burst length in words; changed only when idle and occupancy = 0
- wr_fifo_cnt  in  10  words waiting in the SDRAM write FIFO
- rd_fifo_cnt  in  10  words held in the SDRAM read FIFO
- wr_req  out  1  write-burst request, held until wr_ack
- wr_addr  out  ADDR_W  write-burst start address
- wr_ack  in  1  one-cycle pulse: controller accepted the write burst
- wr_end  in  1  one-cycle pulse: write burst complete
- rd_req  out  1  read-burst request, held until rd_ack
- rd_addr  out  ADDR_W  read-burst start address
- rd_ack  in  1  one-cycle pulse: controller accepted the read burst
- rd_end  in  1  one-cycle pulse: read burst complete
- occupancy  out  ADDR_W+1  words currently stored in the region
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY, GAP.
- Eligibility is computed combinationally and evaluated only in IDLE.
  - wr_elig = init_done & burst_len≠0 & wr_fifo_cnt ≥ burst_len & occupancy + burst_len ≤ DEPTH.
  - rd_elig = init_done & burst_len≠0 & occupancy ≥ burst_len & rd_fifo_cnt + burst_len ≤ RD_FIFO_DEPTH.
  - All sums are computed at (ADDR_W+1) or 11 bits, so nothing overflows.
- IDLE transitions:
  - Only wr_elig → WR_REQ.
  - Only rd_elig → RD_REQ.
  - Both eligible → per arbitration policy (see Configuration).
  - Neither → stay in IDLE.
- Request states:
  - WR_REQ: wr_req=1. On wr_ack → WR_BUSY.
  - RD_REQ: rd_req=1. On rd_ack → RD_BUSY.
- Busy states:
  - WR_BUSY: on wr_end → wr_ptr advances by burst_len, occupancy += burst_len, state → GAP.
  - RD_BUSY: on rd_end → rd_ptr advances by burst_len, occupancy −= burst_len, state → GAP.
- GAP: one cycle so the FIFO counts settle, then → IDLE.
- Address outputs: wr_addr = BASE_ADDR + wr_ptr and rd_addr = BASE_ADDR + rd_ptr, registered and stable from request assertion until the end pulse.
- Pointer wrap: next = ptr + burst_len. If next ≥ DEPTH, next −= DEPTH. A pointer never equals DEPTH.
- Ignored pulses:
  - ack/end of the non-granted direction.
  - ack while in BUSY.
  - end while in REQ.
- The controller guarantees that end comes at least one cycle after ack.
- A write and a read never update occupancy in the same cycle.

## Timing
- Reset values: wr_req=0, rd_req=0, wr_addr=BASE_ADDR, rd_addr=BASE_ADDR, occupancy=0, busy=0; FSM=IDLE, last grant=read.
- Eligibility sampled in IDLE at cycle n → request high at n+1 (registered output).
- Ack at cycle m → request low at m+1.
- End at cycle k → pointer and occupancy updated at k+1 (state GAP), IDLE at k+2, earliest next request k+3.
- init_done falling mid-burst: the burst completes normally; no new request is issued.
- Asserting rst_n low mid-burst aborts it immediately and returns everything to reset values (the SDRAM controller shares rst_n).

## Configuration
- SDRAM_SCHED_RR_EN defined: round-robin when both directions are eligible; grant the direction opposite to the last completed grant. Since reset sets last grant to read, write wins the first tie.
- SDRAM_SCHED_RR_EN undefined: fixed priority, write always wins ties. The last-grant register is not implemented.

## Structure
- Package sdram_sched_pkg holds:
  - FSM state encoding (3-bit localparams S_IDLE..S_GAP).
  - Grant encoding (G_WR=1'b0, G_RD=1'b1).
  - Default ADDR_W.
- Sub-module sdram_ring_ptr: one pointer register with burst_len advance, DEPTH wrap, BASE_ADDR offset and reset. Instantiated twice (write pointer, read pointer).

## Test plan
- Write only: burst_len=10, wr_fifo_cnt=10, init_done=1 → wr_req at n+1, wr_addr=0. After wr_ack/wr_end: occupancy=10, next wr_addr=10, busy low at k+2.
- Read gating: occupancy=10, rd_fifo_cnt=1020, RD_FIFO_DEPTH=1024 → no rd_req. Lower rd_fifo_cnt to 1014 → rd_req with rd_addr=0. After rd_end: occupancy=0.
- Wrap and full: DEPTH=40, burst_len=10 → four writes give occupancy=40 and wr_ptr back to 0. A fifth write is withheld despite wr_fifo_cnt=10. After one read, the next write address is 0.
- Tie: both eligible continuously → with SDRAM_SCHED_RR_EN the grants alternate W,R,W,R. Without it, every grant is W while wr_elig holds.
- Handshake robustness: stray rd_ack/rd_end during a write burst, and wr_end during WR_REQ → no state or occupancy change. Request stays high until ack.
- Reset mid-operation: rst_n low in WR_BUSY with occupancy=20 → all outputs return to reset values, and the next request after release uses address BASE_ADDR.
